// File: rtl/gate3_sweep_ctrl.sv
// Exhaustive in-circuit sweep of a 3-input gate against an AND/OR/NAND/NOR truth table.
// Latency: done pulses 2^N_INPUTS*(SETTLE_CYCLES+1)+1 cycles after start is sampled.
// Backpressure: none; start is ignored while busy or in DONE, abort cancels a running sweep.
module gate3_sweep_ctrl #(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  output logic                i1,
  output logic                i2,
  output logic                i3,
  input  logic                o,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                fail_seen
);

  // A one-cycle settle window still needs a 1-bit counter to keep the datapath legal.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]       CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state;
  logic [N_INPUTS-1:0] vec;
  logic [CW-1:0]       cnt;
  logic [1:0]          mode_q;
  logic                exp_o;

  // Gate inputs come straight from the vector register
  assign i1 = vec[0];
  assign i2 = vec[1];
  assign i3 = vec[2];

  // Expected gate output for the vector currently driven, per the latched mode
  always_comb begin
    exp_o = 1'b0;
    case (mode_q)
      2'b00:   exp_o = &vec;
      2'b01:   exp_o = |vec;
      2'b10:   exp_o = ~&vec;
      default: exp_o = ~|vec;
    endcase
  end

  // Sweep FSM with all status outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vec            <= '0;
      cnt            <= '0;
      mode_q         <= 2'b00;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
      fail_seen      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // abort wins over a simultaneous start
          if (start && !abort) begin
            state          <= SETTLE;
            busy           <= 1'b1;
            vec            <= '0;
            cnt            <= '0;
            mode_q         <= mode;
            err_count      <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          // abort discards this cycle's comparison; partial results stay visible
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            if (o != exp_o) begin
              err_count <= err_count + 1'b1;
              if (!fail_seen) begin
                first_fail_vec <= vec;
                fail_seen      <= 1'b1;
              end
            end
            if (vec == VEC_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              vec   <= vec + 1'b1;
              cnt   <= '0;
              state <= SETTLE;
            end
          end
        end
        DONE: begin
          // err_count already includes the final vector's comparison here
          done  <= 1'b1;
          pass  <= (err_count == '0);
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate3_sweep_ctrl.sv
module tb_gate3_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default build (SETTLE_CYCLES=2)
  logic       a_start, a_abort, a_i1, a_i2, a_i3, a_o, a_busy, a_done, a_pass, a_fs;
  logic [1:0] a_mode;
  logic [3:0] a_err;
  logic [2:0] a_ffv, a_vec;
  // Instance B: SETTLE_CYCLES=1 build
  logic       b_start, b_abort, b_i1, b_i2, b_i3, b_o, b_busy, b_done, b_pass, b_fs;
  logic [1:0] b_mode;
  logic [3:0] b_err;
  logic [2:0] b_ffv;

  int a_kind, b_kind;   // gate under test model: 0 AND3, 1 OR3, 2 stuck-at-1
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] err;
    logic [2:0] ffv;
    logic       fs;
    logic       pass;
    int         lat;
  } exp_t;
  exp_t exp_q[$];
  int   b_done_q[$];

  gate3_sweep_ctrl #(.N_INPUTS(3), .SETTLE_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .mode(a_mode),
    .i1(a_i1), .i2(a_i2), .i3(a_i3), .o(a_o), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_count(a_err), .first_fail_vec(a_ffv), .fail_seen(a_fs)
  );

  gate3_sweep_ctrl #(.N_INPUTS(3), .SETTLE_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .mode(b_mode),
    .i1(b_i1), .i2(b_i2), .i3(b_i3), .o(b_o), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_count(b_err), .first_fail_vec(b_ffv), .fail_seen(b_fs)
  );

  function automatic logic gate_out(input int kind, input logic [2:0] v);
    case (kind)
      0:       return &v;
      1:       return |v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic model_exp(input logic [1:0] m, input logic [2:0] v);
    case (m)
      2'b00:   return &v;
      2'b01:   return |v;
      2'b10:   return ~&v;
      default: return ~|v;
    endcase
  endfunction

  assign a_vec = {a_i3, a_i2, a_i1};
  always_comb a_o = gate_out(a_kind, a_vec);
  always_comb b_o = gate_out(b_kind, {b_i3, b_i2, b_i1});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard entry derived from the truth tables, not from the DUT
  task automatic push_expected(input logic [1:0] m, input int kind, input int settle);
    exp_t e;
    logic [2:0] vv;
    e.err = '0; e.ffv = '0; e.fs = 1'b0;
    for (int v = 0; v < 8; v++) begin
      vv = 3'(v);
      if (gate_out(kind, vv) != model_exp(m, vv)) begin
        if (!e.fs) begin
          e.ffv = vv;
          e.fs  = 1'b1;
        end
        e.err = e.err + 4'd1;
      end
    end
    e.pass = (e.err == 4'd0);
    e.lat  = 8 * (settle + 1) + 1;
    exp_q.push_back(e);
  endtask

  // Full sweep on instance A; optional start pokes while busy must be ignored
  task automatic run_a(input logic [1:0] m, input int kind, input bit pokes, input string tag);
    exp_t e;
    int   c;
    int   bad_vec;
    bit   got;
    a_kind = kind;
    push_expected(m, kind, 2);
    @(negedge clk); a_mode = m; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    c = 0; bad_vec = 0; got = 1'b0;
    while (c < 60) begin
      if (a_done) begin
        got = 1'b1;
        break;
      end
      if (c < 24 && (a_vec != 3'(c / 3) || !a_busy)) bad_vec++;
      a_start = (pokes && (c == 4 || c == 11 || c == 20));
      @(negedge clk); c++;
    end
    a_start = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(c), 32'(e.lat));
    check({tag, "_vec_seq"}, 32'(bad_vec), 32'd0);
    check({tag, "_err_count"}, 32'(a_err), 32'(e.err));
    check({tag, "_first_fail"}, 32'(a_ffv), 32'(e.ffv));
    check({tag, "_fail_seen"}, 32'(a_fs), 32'(e.fs));
    check({tag, "_pass"}, 32'(a_pass), 32'(e.pass));
    check({tag, "_busy_at_done"}, 32'(a_busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(a_done), 32'd0);
  endtask

  initial begin
    int c;
    int dones;
    int idle_cyc;
    int exp_c;
    rst_n = 1'b0;
    a_start = 1'b0; a_abort = 1'b0; a_mode = 2'b00; a_kind = 0;
    b_start = 1'b0; b_abort = 1'b0; b_mode = 2'b00; b_kind = 0;
    #12;
    check("rst_vec", 32'(a_vec), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_pass", 32'(a_pass), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_ffv", 32'(a_ffv), 32'd0);
    check("rst_fs", 32'(a_fs), 32'd0);
    check("rst_b_busy", 32'(b_busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Good AND3, wrong-model OR3, stuck-at-1 against OR and NOR, all-mismatch NAND
    run_a(2'b00, 0, 1'b0, "and_good");
    run_a(2'b00, 1, 1'b0, "or_as_and");
    run_a(2'b01, 2, 1'b0, "stuck1_or");
    run_a(2'b11, 2, 1'b0, "stuck1_nor");
    run_a(2'b10, 0, 1'b0, "and_as_nand");

    // abort while vector 4 is settling
    a_kind = 1;
    @(negedge clk); a_mode = 2'b00; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_pre_vec", 32'(a_vec), 32'd4);
    check("abort_pre_busy", 32'(a_busy), 32'd1);
    a_abort = 1'b1;
    @(negedge clk); a_abort = 1'b0;
    check("abort_busy", 32'(a_busy), 32'd0);
    check("abort_vec_hold", 32'(a_vec), 32'd4);
    check("abort_pass", 32'(a_pass), 32'd0);
    check("abort_err_partial", 32'(a_err), 32'd3);
    check("abort_ffv_partial", 32'(a_ffv), 32'd1);
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (a_done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_a(2'b00, 0, 1'b0, "after_abort");

    // asynchronous reset while vector 5 is settling
    a_kind = 0;
    @(negedge clk); a_mode = 2'b10; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    repeat (15) @(negedge clk);
    check("rstmid_pre_vec", 32'(a_vec), 32'd5);
    check("rstmid_pre_err", 32'(a_err), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_vec", 32'(a_vec), 32'd0);
    check("rstmid_busy", 32'(a_busy), 32'd0);
    check("rstmid_err", 32'(a_err), 32'd0);
    check("rstmid_ffv", 32'(a_ffv), 32'd0);
    check("rstmid_fs", 32'(a_fs), 32'd0);
    check("rstmid_pass", 32'(a_pass), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (a_done) dones++;
      @(negedge clk);
    end
    check("rstmid_no_done", 32'(dones), 32'd0);
    run_a(2'b00, 1, 1'b1, "pokes_ignored");

    // SETTLE_CYCLES=1 build with start held high: back-to-back sweeps
    b_kind = 0;
    @(negedge clk); b_mode = 2'b00; b_start = 1'b1;
    b_done_q.push_back(17);
    b_done_q.push_back(35);
    b_done_q.push_back(53);
    @(negedge clk);
    c = 0; dones = 0; idle_cyc = 0;
    while (c < 54) begin
      if (!b_busy) idle_cyc++;
      if (b_done) begin
        dones++;
        exp_c = (b_done_q.size() > 0) ? b_done_q.pop_front() : -1;
        check("b2b_done_cycle", 32'(c), 32'(exp_c));
        check("b2b_pass", 32'(b_pass), 32'd1);
      end
      @(negedge clk); c++;
    end
    b_start = 1'b0;
    check("b2b_done_count", 32'(dones), 32'd3);
    check("b2b_not_busy_cycles", 32'(idle_cyc), 32'd6);

    repeat (30) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
